// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the alu/gpr/dm/npc datapath.
// The master side is the controller; the slave side is the datapath.
interface mc_ctrl_if;
    logic [31:0] instr;
    logic        alu_zero;
    logic        dm_ready;
    logic        pc_wr;
    logic        ir_wr;
    logic [1:0]  npc_sel;
    logic        reg_dst;
    logic        reg_wr;
    logic        mem_to_reg;
    logic        alu_src;
    logic        ext_op;
    logic [3:0]  alu_ctl;
    logic        dm_rd;
    logic        dm_wr;

    modport master (
        input  instr, alu_zero, dm_ready,
        output pc_wr, ir_wr, npc_sel, reg_dst, reg_wr, mem_to_reg,
               alu_src, ext_op, alu_ctl, dm_rd, dm_wr
    );

    modport slave (
        output instr, alu_zero, dm_ready,
        input  pc_wr, ir_wr, npc_sel, reg_dst, reg_wr, mem_to_reg,
               alu_src, ext_op, alu_ctl, dm_rd, dm_wr
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the addu/subu/ori/lui/sw/lw/beq/j datapath,
// with dm ready/timeout handshake, halt reporting and a retired-instruction counter.
module mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    mc_ctrl_if.master       bus,
    output logic [2:0]      state,
    output logic            halted,
    output logic            illegal,
    output logic            bus_err,
    output logic [31:0]     instr_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXE    = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t        cur, nxt;
    logic [CW-1:0] wait_cnt;
    logic          timeout;

    logic [5:0] op, funct;
    logic is_r, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, legal;
    logic unused_instr;

    assign op    = bus.instr[31:26];
    assign funct = bus.instr[5:0];
    assign unused_instr = ^bus.instr[25:6];

    assign is_r    = (op == 6'b000000);
    assign is_addu = is_r && (funct == 6'b100001);
    assign is_subu = is_r && (funct == 6'b100011);
    assign is_ori  = (op == 6'b001101);
    assign is_lui  = (op == 6'b001111);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_beq  = (op == 6'b000100);
    assign is_j    = (op == 6'b000010);
    assign legal   = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq | is_j;

    assign timeout = (wait_cnt == CW'(MEM_TIMEOUT - 1));
    assign state   = cur;
    assign halted  = (cur == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur       <= IDLE;
            wait_cnt  <= '0;
            illegal   <= 1'b0;
            bus_err   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            cur <= nxt;
            if (cur != MEM)
                wait_cnt <= '0;
            else if (!bus.dm_ready)
                wait_cnt <= wait_cnt + CW'(1);
            if (cur == DECODE && nxt == HALT)
                illegal <= 1'b1;
            if (cur == MEM && nxt == HALT)
                bus_err <= 1'b1;
            // IDLE->FETCH is the only entry into FETCH that retires nothing
            if (nxt == FETCH && cur != IDLE)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end

    always_comb begin
        nxt            = cur;
        bus.pc_wr      = 1'b0;
        bus.ir_wr      = 1'b0;
        bus.npc_sel    = 2'b00;
        bus.reg_dst    = 1'b0;
        bus.reg_wr     = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src    = 1'b0;
        bus.ext_op     = 1'b0;
        bus.alu_ctl    = 4'b0000;
        bus.dm_rd      = 1'b0;
        bus.dm_wr      = 1'b0;

        // ALU controls stay valid through MEM and WB: there is no ALUOut register
        if (cur == EXE || cur == MEM || cur == WB) begin
            if (is_addu || is_lw || is_sw)
                bus.alu_ctl = 4'b0010;
            else if (is_subu || is_beq)
                bus.alu_ctl = 4'b0110;
            else if (is_ori)
                bus.alu_ctl = 4'b0001;
            else if (is_lui)
                bus.alu_ctl = 4'b1000;
            bus.alu_src = is_ori | is_lui | is_lw | is_sw;
            bus.ext_op  = is_lw | is_sw | is_beq;
        end

        case (cur)
            IDLE: nxt = FETCH;
            FETCH: begin
                bus.ir_wr = 1'b1;
                bus.pc_wr = 1'b1;
                nxt       = DECODE;
            end
            DECODE: begin
                if (is_j) begin
                    bus.pc_wr   = 1'b1;
                    bus.npc_sel = 2'b10;
                    nxt         = FETCH;
                end else if (!legal) begin
                    nxt = HALT;
                end else begin
                    nxt = EXE;
                end
            end
            EXE: begin
                if (is_beq) begin
                    bus.npc_sel = 2'b01;
                    bus.pc_wr   = bus.alu_zero;
                    nxt         = FETCH;
                end else if (is_lw || is_sw) begin
                    nxt = MEM;
                end else begin
                    nxt = WB;
                end
            end
            MEM: begin
                bus.dm_rd = is_lw;
                bus.dm_wr = is_sw;
                if (bus.dm_ready)
                    nxt = is_lw ? WB : FETCH;
                else if (timeout)
                    nxt = HALT;
            end
            WB: begin
                bus.reg_wr     = 1'b1;
                bus.reg_dst    = is_r;
                bus.mem_to_reg = is_lw;
                nxt            = FETCH;
            end
            HALT: nxt = HALT;
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: an instruction-level timeline model predicts every cycle's
// outputs; literal expectations pin cycle counts, state sequences and counters.
module tb_mc_ctrl;

    localparam int unsigned TO = 15;

    typedef struct packed {
        logic [2:0]  st;
        logic        pc_wr;
        logic        ir_wr;
        logic [1:0]  npc_sel;
        logic        reg_dst;
        logic        reg_wr;
        logic        mem_to_reg;
        logic        alu_src;
        logic        ext_op;
        logic [3:0]  alu_ctl;
        logic        dm_rd;
        logic        dm_wr;
        logic        halted;
        logic        illegal;
        logic        bus_err;
        logic [31:0] cnt;
    } obs_t;

    logic        clk;
    logic        rst;
    logic [2:0]  state;
    logic        halted, illegal, bus_err;
    logic [31:0] instr_cnt;

    mc_ctrl_if bus ();

    mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state     (state),
        .halted    (halted),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    obs_t        exp_q[$];
    obs_t        seen[$];
    logic [31:0] m_cnt;
    logic        m_ill, m_bus;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic obs_t snap();
        return {state, bus.pc_wr, bus.ir_wr, bus.npc_sel, bus.reg_dst, bus.reg_wr,
                bus.mem_to_reg, bus.alu_src, bus.ext_op, bus.alu_ctl, bus.dm_rd,
                bus.dm_wr, halted, illegal, bus_err, instr_cnt};
    endfunction

    // Compare process: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = snap();
            seen.push_back(a);
            check($sformatf("cycle st=%0d", e.st), a, e);
        end
    end

    function automatic int unsigned count_st(input logic [2:0] s);
        int unsigned n = 0;
        foreach (seen[k]) if (seen[k].st == s) n++;
        return n;
    endfunction

    function automatic int unsigned count_rd();
        int unsigned n = 0;
        foreach (seen[k]) if (seen[k].dm_rd) n++;
        return n;
    endfunction

    // Called just after a rising edge; drives one cycle and queues its expectation.
    task automatic cyc(input logic [31:0] i, input logic z, input logic r, input obs_t e);
        bus.instr    = i;
        bus.alu_zero = z;
        bus.dm_ready = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model: expands one instruction into its cycle timeline.
    task automatic exec(input logic [31:0] i, input logic z, input int unsigned waits,
                        input int unsigned abort_after);
        logic [5:0] op, fn;
        bit radd, rsub, ori, lui, lw, sw, beq, jmp, ok;
        obs_t b, e;
        op   = i[31:26];
        fn   = i[5:0];
        radd = (op == 6'h00) && (fn == 6'h21);
        rsub = (op == 6'h00) && (fn == 6'h23);
        ori  = (op == 6'h0D);
        lui  = (op == 6'h0F);
        lw   = (op == 6'h23);
        sw   = (op == 6'h2B);
        beq  = (op == 6'h04);
        jmp  = (op == 6'h02);
        ok   = radd | rsub | ori | lui | lw | sw | beq | jmp;
        seen.delete();

        b = '0; b.cnt = m_cnt; b.illegal = m_ill; b.bus_err = m_bus;
        e = b; e.st = 3'd1; e.pc_wr = 1'b1; e.ir_wr = 1'b1;
        cyc(i, z, 1'b0, e);
        e = b; e.st = 3'd2;
        if (jmp) begin e.pc_wr = 1'b1; e.npc_sel = 2'b10; end
        cyc(i, z, 1'b0, e);
        if (jmp) begin m_cnt++; return; end
        if (!ok) begin
            m_ill = 1'b1;
            e = b; e.st = 3'd6; e.halted = 1'b1; e.illegal = 1'b1;
            repeat (3) cyc(i, z, 1'b0, e);
            return;
        end

        b.alu_ctl = (radd || lw || sw) ? 4'b0010 : (rsub || beq) ? 4'b0110 :
                    ori ? 4'b0001 : 4'b1000;
        b.alu_src = ori | lui | lw | sw;
        b.ext_op  = lw | sw | beq;
        e = b; e.st = 3'd3;
        if (beq) begin e.npc_sel = 2'b01; e.pc_wr = z; end
        cyc(i, z, 1'b0, e);
        if (beq) begin m_cnt++; return; end

        if (lw || sw) begin
            e = b; e.st = 3'd4; e.dm_rd = lw; e.dm_wr = sw;
            if (abort_after != 0) begin
                repeat (abort_after) cyc(i, z, 1'b0, e);
                return;
            end
            if (waits >= TO) begin
                repeat (TO) cyc(i, z, 1'b0, e);
                m_bus = 1'b1;
                e = '0; e.st = 3'd6; e.halted = 1'b1; e.bus_err = 1'b1;
                e.illegal = m_ill; e.cnt = m_cnt;
                repeat (3) cyc(i, z, 1'b0, e);
                return;
            end
            repeat (waits) cyc(i, z, 1'b0, e);
            cyc(i, z, 1'b1, e);
            if (sw) begin m_cnt++; return; end
        end

        e = b; e.st = 3'd5; e.reg_wr = 1'b1; e.reg_dst = radd | rsub; e.mem_to_reg = lw;
        cyc(i, z, 1'b0, e);
        m_cnt++;
    endtask

    task automatic do_reset();
        obs_t e;
        rst = 1'b0;
        #1;
        check("reset_outputs", snap(), '0);
        m_cnt = '0; m_ill = 1'b0; m_bus = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        e = '0;
        cyc(bus.instr, 1'b0, 1'b0, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.instr = 32'h0; bus.alu_zero = 1'b0; bus.dm_ready = 1'b0;
        m_cnt = '0; m_ill = 1'b0; m_bus = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        exec(32'h00221821, 1'b0, 0, 0);                  // addu $3,$1,$2
        check("addu_len", seen.size(), 4);
        check("addu_states", {seen[0].st, seen[1].st, seen[2].st, seen[3].st}, 12'b001_010_011_101);
        check("addu_wb", {seen[3].reg_wr, seen[3].reg_dst, seen[3].alu_ctl}, 6'b11_0010);
        check("addu_cnt", instr_cnt, 32'd1);

        exec(32'h00221823, 1'b0, 0, 0);                  // subu
        check("subu_alu", seen[2].alu_ctl, 4'b0110);
        exec(32'h34220005, 1'b0, 0, 0);                  // ori
        check("ori_src", {seen[2].alu_src, seen[2].ext_op, seen[2].alu_ctl}, 6'b10_0001);
        exec(32'h3C011234, 1'b0, 0, 0);                  // lui

        exec(32'h8C220004, 1'b0, 3, 0);                  // lw, 3 wait states
        check("lw_rd_cycles", count_rd(), 4);
        check("lw_wb", {seen[seen.size()-1].st, seen[seen.size()-1].mem_to_reg}, 4'b101_1);
        exec(32'hAC220004, 1'b0, 0, 0);                  // sw, ready at once
        check("sw_len", seen.size(), 4);
        check("sw_mem_cycles", count_st(3'd4), 1);

        exec(32'h10220003, 1'b1, 0, 0);                  // beq taken
        check("beq_taken", {seen[2].pc_wr, seen[2].npc_sel}, 3'b1_01);
        exec(32'h10220003, 1'b0, 0, 0);                  // beq not taken
        check("beq_not_taken", {seen[2].pc_wr, seen[2].npc_sel}, 3'b0_01);
        check("beq_len", seen.size(), 3);

        exec(32'h08000C00, 1'b0, 0, 0);                  // j
        check("j_len", seen.size(), 2);
        check("j_decode", {seen[1].pc_wr, seen[1].npc_sel}, 3'b1_10);
        check("j_cnt", instr_cnt, 32'd9);
        check("j_refetch", state, 3'd1);

        exec(32'hFC000000, 1'b0, 0, 0);                  // opcode 0x3F
        check("ill_op_flags", {halted, illegal, bus_err}, 3'b110);
        check("ill_op_cnt", instr_cnt, 32'd9);

        do_reset();
        exec(32'h00221820, 1'b0, 0, 0);                  // R-type funct 0x20
        check("ill_funct_flags", {state, halted, illegal}, 5'b110_11);
        check("ill_funct_cnt", instr_cnt, 32'd0);

        do_reset();
        exec(32'h8C220004, 1'b0, TO, 0);                 // lw, dm never ready
        check("timeout_mem_cycles", count_st(3'd4), TO);
        check("timeout_flags", {halted, illegal, bus_err}, 3'b101);

        do_reset();
        exec(32'hAC220004, 1'b0, 0, 2);                  // sw, reset mid-MEM
        bus.dm_ready = 1'b0;
        check("midmem_before", {state, bus.dm_wr}, 4'b100_1);
        rst = 1'b0;
        #1;
        check("midmem_after", {state, bus.dm_wr}, 4'b000_0);
        do_reset();
        exec(32'h00221821, 1'b0, 0, 0);
        check("resume_cnt", instr_cnt, 32'd1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer that replaces the single-cycle `ctrl` decode so the existing `alu`, `gpr`, `dm`, `npc`/`pc` datapath executes one instruction over several clocks. It supports addu, subu, ori, lui, sw, lw, beq and j. It owns the instruction-register and PC write strobes and handshakes data-memory accesses with `dm` through a ready signal and a timeout. It also reports halts and counts retired instructions.

## Interface
- `MEM_TIMEOUT`, default 15: maximum number of cycles spent in MEM before a bus error is raised. Must be ≥1.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instr`  in  32  IR contents from the datapath; stable from DECODE onward.
- `alu_zero`  in  1  ALU zero flag.
- `dm_ready`  in  1  dm access complete; sampled only in MEM.
- `pc_wr`  out  1  PC load strobe.
- `ir_wr`  out  1  IR load strobe.
- `npc_sel`  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- `reg_dst`  out  1  1 = rd, 0 = rt.
- `reg_wr`  out  1  GPR write enable.
- `mem_to_reg`  out  1  1 = GPR write data from dm.
- `alu_src`  out  1  1 = extended imm16 as ALU operand B.
- `ext_op`  out  1  1 = sign-extend, 0 = zero-extend.
- `alu_ctl`  out  4  0010 add, 0110 sub, 0001 or, 1000 lui (imm16<<16).
- `dm_rd`, `dm_wr`  out  1 each  data-memory strobes.
- `state`  out  3  current state, for debug.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky; set when the controller halts on an undecodable instruction.
- `bus_err`  out  1  sticky; set when the controller halts on a MEM timeout.
- `instr_cnt`  out  32  retired-instruction count.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXE=3, MEM=4, WB=5, HALT=6.
- Decode rules:
  - R-type is opcode 000000 with funct 100001 (addu) or 100011 (subu).
  - ori = 001101, lui = 001111, lw = 100011, sw = 101011, beq = 000100, j = 000010.
  - Anything else is illegal.
- Transitions:
  - IDLE→FETCH unconditionally.
  - FETCH→DECODE.
  - DECODE:
    - j → FETCH.
    - illegal → HALT, and `illegal` is set.
    - otherwise → EXE.
  - EXE:
    - beq → FETCH.
    - lw/sw → MEM.
    - others → WB.
  - MEM:
    - `dm_ready`=1: lw → WB; sw → FETCH.
    - wait timeout reached → HALT, and `bus_err` is set.
  - WB→FETCH.
  - HALT is held until reset.
- Outputs are decoded combinationally from the state and `instr`. Any output not listed for a state is 0.
  - FETCH: `ir_wr`=1, `pc_wr`=1, `npc_sel`=00.
  - DECODE, j only: `pc_wr`=1, `npc_sel`=10.
  - EXE, MEM and WB:
    - `alu_ctl`: add for addu/lw/sw, sub for subu/beq, or for ori, lui for lui.
    - `alu_src`=1 for ori/lui/lw/sw.
    - `ext_op`=1 for lw/sw/beq.
    - These are held through MEM and WB so that the ALU result and address stay stable (there is no ALUOut register).
  - EXE, beq only: `npc_sel`=01, `pc_wr`=`alu_zero`.
  - MEM: `dm_rd`=1 for lw, `dm_wr`=1 for sw. Both are held until the cycle `dm_ready` is sampled high.
  - WB: `reg_wr`=1, `reg_dst`=1 for R-type, `mem_to_reg`=1 for lw.
- MEM wait counter:
  - Cleared on MEM entry; increments every MEM cycle with `dm_ready`=0.
  - `dm_ready`=1 has priority over the timeout.
  - `dm_ready`=0 while count == MEM_TIMEOUT−1 → HALT. At most MEM_TIMEOUT cycles are therefore spent in MEM.
- `instr_cnt`:
  - Increments by 1 on each transition into FETCH from DECODE, EXE, MEM or WB; the IDLE→FETCH transition does not count.
  - Wraps from FFFF_FFFF to 0.
  - Halting instructions are not counted.

## Timing
- Reset asserted at any time, including mid-MEM: state→IDLE immediately; `illegal`, `bus_err`, `instr_cnt` and the wait counter→0; all strobes 0.
- Cycle counts, including FETCH, with zero wait states:
  - j: 2.
  - beq: 3.
  - addu/subu/ori/lui: 4.
  - sw: 4 plus waits.
  - lw: 5 plus waits.
- First FETCH occurs in the second cycle after `rst` is released.
- `pc_wr`/`ir_wr` are single-cycle pulses. No strobe is ever asserted in IDLE or HALT.

## Test plan
- Reset release, then addu $3,$1,$2 (0x00221821): states 1,2,3,5; WB shows `reg_wr`=1, `reg_dst`=1, `alu_ctl`=0010; after WB, `instr_cnt`=1.
- lw with `dm_ready` low for 3 cycles: `dm_rd` high for exactly 4 MEM cycles, then WB with `mem_to_reg`=1. sw with `dm_ready`=1: a single MEM cycle, then FETCH.
- beq with `alu_zero`=1 → EXE pulses `pc_wr`, `npc_sel`=01. With `alu_zero`=0 → `pc_wr`=0 in EXE. Both cases return to FETCH.
- j (0x08000C00) → `pc_wr`=1, `npc_sel`=10 in DECODE, then FETCH; `instr_cnt` increments.
- Illegal opcode 0x3F and R-type funct 0x20 → HALT, `illegal`=1, `halted`=1, no further strobes. lw with `dm_ready` held low → exactly 15 MEM cycles, then HALT with `bus_err`=1.
- Async reset asserted mid-MEM with `dm_wr` high → `dm_wr` drops immediately, `state`=0; after release, normal fetch resumes.
